// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor, one result bit per clock, LSB first
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_nx;
  logic [WIDTH:0]   s_cat;
  logic [CW-1:0]    cnt;
  logic             sub_r;
  logic             cy;
  logic             fa_a;
  logic             fa_b;
  logic             fa_s;
  logic             fa_c;

  // Single full-adder cell; B is inverted in subtract mode (carry FF preloaded with 1)
  always_comb begin
    fa_a  = a_sh[0];
    fa_b  = b_sh[0] ^ sub_r;
    fa_s  = fa_a ^ fa_b ^ cy;
    fa_c  = (fa_a & fa_b) | (cy & (fa_a ^ fa_b));
    s_cat = {fa_s, s_sh};
    s_nx  = s_cat[WIDTH:1];
  end

  // Control FSM plus datapath shift registers; visible results only update on completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      cnt       <= '0;
      cy        <= 1'b0;
      sub_r     <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      s_sh      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            sub_r <= sub;
            cy    <= sub;
            cnt   <= '0;
            s_sh  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          s_sh <= s_nx;
          cy   <= fa_c;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            sum       <= s_nx;
            carry_out <= fa_c;
            overflow  <= cy ^ fa_c;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized and directed checks of serial_adder against an arithmetic model
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, sub;
  logic [7:0] a, b;
  logic       busy, done, carry_out, overflow;
  logic [7:0] sum;

  logic       start1, sub1, a1, b1;
  logic       busy1, done1, sum1, carry_out1, overflow1;

  int total = 0;
  int bad   = 0;
  logic [31:0] prev_sum;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(carry_out1), .overflow(overflow1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic and the signed-overflow sign rule
  task automatic model(input int w, input logic [31:0] x, input logic [31:0] y, input logic s,
                       output logic [31:0] rs, output logic rc, output logic ro);
    longint unsigned mask, yy, full;
    mask = (64'd1 << w) - 1;
    yy   = s ? (~longint'(y) & mask) : (longint'(y) & mask);
    full = (longint'(x) & mask) + yy + (s ? 64'd1 : 64'd0);
    rs   = 32'(full & mask);
    rc   = full[w];
    if (!s) ro = (x[w-1] == y[w-1]) && (rs[w-1] != x[w-1]);
    else    ro = (x[w-1] != y[w-1]) && (rs[w-1] != x[w-1]);
  endtask

  // One WIDTH=8 operation; inj=1 pokes start with other operands mid-RUN and in DONE
  task automatic run8(input logic [7:0] xa, input logic [7:0] xb, input logic xs, input bit inj);
    logic [31:0] es;
    logic ec, eo;
    int lat, bcnt;
    model(8, {24'd0, xa}, {24'd0, xb}, xs, es, ec, eo);
    a = xa; b = xb; sub = xs; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (lat == 2) chk("sum_hold_in_run", {24'd0, sum}, prev_sum);
      if (inj && lat == 3) begin start = 1'b1; a = ~xa; b = xa ^ 8'h5A; sub = ~xs; end
      if (inj && lat == 4) start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 8);
    chk("busy_cycles", bcnt, 8);
    chk("busy_with_done", {31'd0, busy & done}, 32'd0);
    chk("sum", {24'd0, sum}, es);
    chk("carry_out", {31'd0, carry_out}, {31'd0, ec});
    chk("overflow", {31'd0, overflow}, {31'd0, eo});
    if (inj) begin start = 1'b1; a = 8'hAA; b = 8'h55; end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse_end", {31'd0, done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    chk("sum_held", {24'd0, sum}, es);
    prev_sum = es;
  endtask

  task automatic run1(input logic xa, input logic xb, input logic xs);
    logic [31:0] es;
    logic ec, eo;
    model(1, {31'd0, xa}, {31'd0, xb}, xs, es, ec, eo);
    a1 = xa; b1 = xb; sub1 = xs; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    chk("w1_busy", {30'd0, busy1, done1}, 32'd2);
    @(posedge clk);
    @(negedge clk);
    chk("w1_done", {30'd0, busy1, done1}, 32'd1);
    chk("w1_sum", {31'd0, sum1}, es);
    chk("w1_carry", {31'd0, carry_out1}, {31'd0, ec});
    chk("w1_ovf", {31'd0, overflow1}, {31'd0, eo});
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    logic [2:0] v;
    rst_n = 1'b0; start = 1'b1; sub = 1'b0; a = 8'h12; b = 8'h34;
    start1 = 1'b1; sub1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {20'd0, busy, done, sum, carry_out, overflow}, 32'd0);
    chk("rst_outputs_w1", {27'd0, busy1, done1, sum1, carry_out1, overflow1}, 32'd0);
    start = 1'b0; start1 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_after_rst", {30'd0, busy, done}, 32'd0);
    prev_sum = 32'd0;

    run8(8'h0F, 8'h01, 1'b0, 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 1'b0);
    run8(8'h7F, 8'h01, 1'b0, 1'b0);
    run8(8'h05, 8'h07, 1'b1, 1'b0);
    run8(8'h80, 8'h01, 1'b1, 1'b0);
    run8(8'h3C, 8'hA5, 1'b0, 1'b1);

    for (int i = 0; i < 20; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));

    // Reset mid-RUN: no done, everything cleared, then a normal operation
    a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_run_rst", {20'd0, busy, done, sum, carry_out, overflow}, 32'd0);
    rst_n = 1'b1; start = 1'b0;
    lat = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) lat++;
    end
    chk("no_done_after_abort", lat, 0);
    prev_sum = 32'd0;
    run8(8'h5A, 8'h33, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      run1(v[2], v[1], v[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 Port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 Port: sub  input  1  mode select, captured with operands: 0 = a+b, 1 = a-b.
REQ-006 Port: a  input  WIDTH  operand A, captured when start is accepted.
REQ-007 Port: b  input  WIDTH  operand B, captured when start is accepted.
REQ-008 Port: busy  output  1  high while bits are being processed (state RUN).
REQ-009 Port: done  output  1  one-cycle pulse; result outputs valid.
REQ-010 Port: sum  output  WIDTH  result, LSB-first assembled.
REQ-011 Port: carry_out  output  1  final carry out of MSB (sub: 1 = no borrow).
REQ-012 Port: overflow  output  1  two's-complement signed overflow of the result.

Function
REQ-013 The block SHALL compute one result bit per cycle through a single full-adder cell plus a carry flip-flop, LSB first.
REQ-014 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE: start=1 at edge E0 SHALL latch a, b, sub into internal shift registers, load carry FF with sub, clear bit counter, go to RUN.
REQ-016 IDLE with start=0 SHALL remain IDLE with all result outputs held.
REQ-017 In sub mode, the B bit fed to the full adder SHALL be inverted (a + ~b + 1).
REQ-018 RUN: each edge SHALL shift operands right by one, shift the new sum bit into sum MSB side, update carry FF, increment counter.
REQ-019 After WIDTH edges in RUN (edge E0+WIDTH), state SHALL be DONE; done=1 for exactly that one cycle; sum, carry_out, overflow valid.
REQ-020 DONE SHALL return to IDLE on the next edge unconditionally; start in DONE SHALL be ignored.
REQ-021 busy SHALL be 1 exactly in RUN (WIDTH cycles per operation); busy and done SHALL never be high together.
REQ-022 start, a, b, sub changes while busy or in DONE SHALL have no effect on the operation in progress or its results.
REQ-023 carry_out SHALL equal the carry out of bit WIDTH-1; overflow SHALL equal carry-into-MSB XOR carry-out-of-MSB.
REQ-024 sum, carry_out, overflow SHALL hold their last value from DONE until the next operation reaches DONE (intermediate shifting SHALL use internal registers, not visible on sum).
REQ-025 Bit counter width SHALL be $clog2(WIDTH+1); WIDTH=1 SHALL complete in one RUN cycle.
REQ-026 Latency: done SHALL be asserted WIDTH cycles after the edge accepting start; throughput one operation per WIDTH+2 cycles.

Reset
REQ-027 rst_n=0 at an edge SHALL force state IDLE, busy=0, done=0, sum=0, carry_out=0, overflow=0, counter and carry FF cleared.
REQ-028 Reset SHALL take priority over every other input, including mid-RUN and in DONE; an aborted operation SHALL produce no done pulse.
REQ-029 start held high during reset SHALL be ignored; the first acceptable start is at the first edge with rst_n=1.

Verification (WIDTH=8 unless stated)
REQ-030 add a=8'h0F b=8'h01 sub=0 -> after 8 cycles done=1, sum=8'h10, carry_out=0, overflow=0; busy high exactly 8 cycles.
REQ-031 add 8'hFF+8'h01 -> sum=8'h00, carry_out=1, overflow=0; add 8'h7F+8'h01 -> sum=8'h80, carry_out=0, overflow=1.
REQ-032 sub 8'h05-8'h07 -> sum=8'hFE, carry_out=0, overflow=0; sub 8'h80-8'h01 -> sum=8'h7F, carry_out=1, overflow=1.
REQ-033 start pulsed with new operands at RUN cycle 3 and in DONE -> ignored; result matches first operands; single done pulse.
REQ-034 rst_n=0 at RUN cycle 4 -> next cycle IDLE, all outputs 0, no done; new start after release completes normally.
REQ-035 WIDTH=1 exhaustive: all 8 (a,b,sub) combinations -> done one cycle after start, sum/carry_out match full-adder truth table.
